alu_sequencer: RTL and testbench

Single-issue execution controller for the 16-bit `alu` datapath. It accepts one encoded instruction at a time over a valid/ready handshake and reads two operands from an internal 8×16 register file. It drives the ALU, writes the result back, and maintains an architectural 6-bit flags register that supplies carry-in for multi-precision chains. A host load/read port gives direct register-file access between instructions.

---
 rtl/alu_pkg.sv | 59 +++++
 rtl/alu.sv | 62 ++++++
 rtl/alu_sequencer.sv | 106 ++++++++++
 tb/tb_alu_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, flag, field and FSM definitions for the 16-bit ALU and its sequencer.
package alu_pkg;
    localparam int DATA_W = 16;
    localparam int FLAG_W = 6;

    localparam logic [4:0] OP_INC = 5'b00001;
    localparam logic [4:0] OP_DEC = 5'b00011;
    localparam logic [4:0] OP_ADD = 5'b00100;
    localparam logic [4:0] OP_ADC = 5'b00101;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_SBB = 5'b00111;
    localparam logic [4:0] OP_AND = 5'b01000;
    localparam logic [4:0] OP_OR  = 5'b01001;
    localparam logic [4:0] OP_XOR = 5'b01010;
    localparam logic [4:0] OP_NOT = 5'b01011;
    localparam logic [4:0] OP_SHL = 5'b10000;
    localparam logic [4:0] OP_SHR = 5'b10001;
    localparam logic [4:0] OP_SAL = 5'b10010;
    localparam logic [4:0] OP_SAR = 5'b10011;
    localparam logic [4:0] OP_ROL = 5'b10100;
    localparam logic [4:0] OP_ROR = 5'b10101;
    localparam logic [4:0] OP_RCL = 5'b10110;
    localparam logic [4:0] OP_RCR = 5'b10111;

    localparam logic [1:0] CLS_ARITH = 2'b00;
    localparam logic [1:0] CLS_LOGIC = 2'b01;
    localparam logic [1:0] CLS_SHIFT = 2'b10;

    localparam int CF = 5;
    localparam int ZF = 4;
    localparam int NF = 3;
    localparam int VF = 2;
    localparam int PF = 1;
    localparam int AF = 0;

    localparam int F_LSB       = 11;
    localparam int RD_LSB      = 8;
    localparam int RA_LSB      = 5;
    localparam int RB_LSB      = 2;
    localparam int CIN_SEL_BIT = 1;
    localparam int FLAG_WE_BIT = 0;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    function automatic logic op_legal(input logic [4:0] f);
        return (f == OP_INC) || (f == OP_DEC) || (f[4:2] == 3'b001) ||
               (f[4:2] == 3'b010) || (f[4:3] == 2'b10);
    endfunction

    // Logic ops keep ZF/NF/PF; shifts additionally keep CF.
    function automatic logic [FLAG_W-1:0] flag_mask(input logic [4:0] f,
                                                    input logic [FLAG_W-1:0] s);
        case (f[4:3])
            CLS_LOGIC: return s & 6'b011010;
            CLS_SHIFT: return s & 6'b111010;
            default:   return s;
        endcase
    endfunction
endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU: arithmetic, logic and single-bit shift/rotate ops with six status flags.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        f,
    input  logic              cin,
    output logic [DATA_W-1:0] result,
    output logic [FLAG_W-1:0] status
);
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] res;
    logic [DATA_W:0]   sum;
    logic              sub;
    logic              c0;
    logic              cf;
    logic              vf;
    logic              af;

    always_comb begin
        opb = b;
        sub = 1'b0;
        c0  = 1'b0;
        case (f)
            OP_INC:  opb = 16'd1;
            OP_DEC:  begin opb = 16'd1; sub = 1'b1; end
            OP_ADC:  c0 = cin;
            OP_SUB:  sub = 1'b1;
            OP_SBB:  begin sub = 1'b1; c0 = cin; end
            default: ;
        endcase

        // CF is carry-out for add, borrow for subtract.
        sum = sub ? ({1'b0, a} - {1'b0, opb} - {16'd0, c0})
                  : ({1'b0, a} + {1'b0, opb} + {16'd0, c0});
        res = sum[DATA_W-1:0];
        cf  = sum[DATA_W];
        vf  = sub ? ((a[15] != opb[15]) && (sum[15] != a[15]))
                  : ((a[15] == opb[15]) && (sum[15] != a[15]));
        af  = a[4] ^ opb[4] ^ sum[4];

        case (f)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOT:  res = ~a;
            OP_SHL,
            OP_SAL:  begin res = {a[14:0], 1'b0}; cf = a[15]; end
            OP_SHR:  begin res = {1'b0, a[15:1]}; cf = a[0];  end
            OP_SAR:  begin res = {a[15], a[15:1]}; cf = a[0]; end
            OP_ROL:  begin res = {a[14:0], a[15]}; cf = a[15]; end
            OP_ROR:  begin res = {a[0], a[15:1]};  cf = a[0];  end
            OP_RCL:  begin res = {a[14:0], cin};   cf = a[15]; end
            OP_RCR:  begin res = {cin, a[15:1]};   cf = a[0];  end
            default: ;
        endcase

        result = res;
        status = {cf, (res == '0), res[15], vf, ~^res, af};
    end
endmodule

// File: rtl/alu_sequencer.sv
// Four-state single-issue controller: latches an instruction, reads operands, executes, writes back.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    input  logic              reg_we,
    input  logic [2:0]        reg_waddr,
    input  logic [15:0]       reg_wdata,
    input  logic [2:0]        reg_raddr,
    output logic [15:0]       reg_rdata,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic [FLAG_W-1:0] flags
);
    state_t            state;
    logic [15:0]       instr_q;
    logic [DATA_W-1:0] rf [NREGS];
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              cin_q;
    logic [DATA_W-1:0] ex_res;
    logic [FLAG_W-1:0] ex_flags;
    logic              ex_legal;
    logic [DATA_W-1:0] alu_res;
    logic [FLAG_W-1:0] alu_stat;

    logic [4:0] f_q;
    logic [2:0] rd_q, ra_q, rb_q;
    assign f_q  = instr_q[F_LSB +: 5];
    assign rd_q = instr_q[RD_LSB +: 3];
    assign ra_q = instr_q[RA_LSB +: 3];
    assign rb_q = instr_q[RB_LSB +: 3];

    assign instr_ready = (state == IDLE) && !rst;
    assign reg_rdata   = rf[reg_raddr];

    alu u_alu (
        .a      (op_a),
        .b      (op_b),
        .f      (f_q),
        .cin    (cin_q),
        .result (alu_res),
        .status (alu_stat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            err      <= 1'b0;
            result   <= '0;
            flags    <= '0;
            instr_q  <= '0;
            op_a     <= '0;
            op_b     <= '0;
            cin_q    <= 1'b0;
            ex_res   <= '0;
            ex_flags <= '0;
            ex_legal <= 1'b0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    // Host writes land only here, so a same-cycle accept reads the new value in READ.
                    if (reg_we) rf[reg_waddr] <= reg_wdata;
                    if (instr_valid) begin
                        instr_q <= instr;
                        state   <= READ;
                    end
                end
                READ: begin
                    op_a  <= rf[ra_q];
                    op_b  <= rf[rb_q];
                    cin_q <= instr_q[CIN_SEL_BIT] & flags[CF];
                    state <= EXEC;
                end
                EXEC: begin
                    ex_res   <= alu_res;
                    ex_flags <= flag_mask(f_q, alu_stat);
                    ex_legal <= op_legal(f_q);
                    done     <= 1'b1;
                    err      <= !op_legal(f_q);
                    state    <= WB;
                end
                WB: begin
                    if (ex_legal) begin
                        rf[rd_q] <= ex_res;
                        result   <= ex_res;
                        if (instr_q[FLAG_WE_BIT]) flags <= ex_flags;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed-vector bench: stimulus pushes expected responses, a monitor pops them on each done pulse.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        reg_we;
    logic [2:0]  reg_waddr;
    logic [15:0] reg_wdata;
    logic [2:0]  reg_raddr;
    logic [15:0] reg_rdata;
    logic        done;
    logic        err;
    logic [15:0] result;
    logic [5:0]  flags;

    alu_sequencer #(.NREGS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .reg_we      (reg_we),
        .reg_waddr   (reg_waddr),
        .reg_wdata   (reg_wdata),
        .reg_raddr   (reg_raddr),
        .reg_rdata   (reg_rdata),
        .done        (done),
        .err         (err),
        .result      (result),
        .flags       (flags)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        e_err;
        logic [15:0] e_res;
        logic [5:0]  e_flg;
        int unsigned t;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   pass_cnt = 0;
    int   total    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [15:0] mk(input logic [4:0] f, input logic [2:0] rd,
                                       input logic [2:0] ra, input logic [2:0] rb,
                                       input logic cs, input logic fw);
        return {f, rd, ra, rb, cs, fw};
    endfunction

    // Monitor: done pulses are checked against the queue, result/flags one cycle later.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("err", {31'd0, err}, {31'd0, mon_e.e_err});
                    chk("done_latency", cyc - mon_e.t, 32'd3);
                    @(negedge clk);
                    chk("result", {16'd0, result}, {16'd0, mon_e.e_res});
                    chk("flags", {26'd0, flags}, {26'd0, mon_e.e_flg});
                end
            end
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_ready === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [4:0] f, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input logic cs, input logic fw,
                         input logic x_err, input logic [15:0] x_res, input logic [5:0] x_flg);
        bit ok;
        wait_ready(ok);
        if (ok) begin
            instr_valid = 1'b1;
            instr       = mk(f, rd, ra, rb, cs, fw);
            sb.push_back('{x_err, x_res, x_flg, cyc});
            @(negedge clk);
            instr_valid = 1'b0;
            instr       = 16'hA5A5;
            repeat (4) @(negedge clk);
            chk("sb_drained", sb.size(), 32'd0);
        end
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        reg_we = 1'b1; reg_waddr = a; reg_wdata = d;
        @(negedge clk);
        reg_we = 1'b0;
    endtask

    task automatic chk_reg(input string name, input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        reg_raddr = a;
        #1 chk(name, {16'd0, reg_rdata}, {16'd0, d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned acc_t[$];
        bit ok;
        rst = 1'b1; instr_valid = 1'b0; instr = '0;
        reg_we = 1'b0; reg_waddr = '0; reg_wdata = '0; reg_raddr = '0;

        repeat (2) @(negedge clk);
        chk("ready_in_reset", {31'd0, instr_ready}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_flags", {26'd0, flags}, 32'd0);
        rst = 1'b0;
        #1 chk("ready_after_reset", {31'd0, instr_ready}, 32'd1);
        for (int i = 0; i < 8; i++) chk_reg("rst_rf", 3'(i), 16'h0000);

        // ADD with signed overflow
        load(3'd1, 16'h7FFF);
        load(3'd2, 16'h0001);
        issue(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 16'h8000, 6'b001101);
        chk_reg("add_r3", 3'd3, 16'h8000);

        // Carry chain: ADD sets CF, ADC consumes it
        load(3'd1, 16'hFFFF);
        issue(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 16'h0000, 6'b110011);
        chk_reg("carry_r3", 3'd3, 16'h0000);
        issue(OP_ADC, 3'd4, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0001, 6'b110011);
        chk_reg("adc_r4", 3'd4, 16'h0001);

        // Rotate through carry (CF=1 going in)
        load(3'd1, 16'h8001);
        issue(OP_RCL, 3'd2, 3'd1, 3'd0, 1'b1, 1'b1, 1'b0, 16'h0003, 6'b100010);
        chk_reg("rcl_r2", 3'd2, 16'h0003);

        // Illegal opcode leaves everything untouched
        load(3'd5, 16'h1234);
        issue(5'b00000, 3'd5, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1, 16'h0003, 6'b100010);
        chk_reg("illegal_r5", 3'd5, 16'h1234);

        // Logic op masks CF/VF/AF; subtract produces a borrow
        issue(OP_XOR, 3'd6, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 16'h8002, 6'b001010);
        chk_reg("xor_r6", 3'd6, 16'h8002);
        issue(OP_SUB, 3'd7, 3'd0, 3'd4, 1'b0, 1'b1, 1'b0, 16'hFFFF, 6'b101011);
        chk_reg("sub_r7", 3'd7, 16'hFFFF);

        // Back-to-back issue with a dropped host write during EXEC
        wait_ready(ok);
        instr_valid = 1'b1;
        instr       = mk(OP_INC, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (instr_ready === 1'b1) begin
                acc_t.push_back(cyc);
                sb.push_back('{1'b0, 16'h0001, 6'b101011, cyc});
            end
            if (i == 2) begin reg_we = 1'b1; reg_waddr = 3'd6; reg_wdata = 16'hBEEF; end
            else reg_we = 1'b0;
        end
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("accept_count", acc_t.size(), 32'd3);
        if (acc_t.size() == 3) begin
            chk("accept_gap0", acc_t[1] - acc_t[0], 32'd4);
            chk("accept_gap1", acc_t[2] - acc_t[1], 32'd4);
        end
        chk("b2b_sb_drained", sb.size(), 32'd0);
        chk_reg("dropped_write_r6", 3'd6, 16'h8002);
        chk_reg("inc_r1", 3'd1, 16'h0001);

        // Reset during EXEC discards the instruction
        wait_ready(ok);
        instr_valid = 1'b1;
        instr       = mk(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 1'b1);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_ready", {31'd0, instr_ready}, 32'd0);
        chk("midrst_flags", {26'd0, flags}, 32'd0);
        chk("midrst_result", {16'd0, result}, 32'd0);
        rst = 1'b0;
        #1 chk("midrst_ready_release", {31'd0, instr_ready}, 32'd1);
        for (int i = 0; i < 8; i++) chk_reg("midrst_rf", 3'(i), 16'h0000);
        repeat (4) @(negedge clk);
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
